// File: rtl/video_timing_rx.sv
// video_timing_rx: measures incoming hs/vs/de line and frame geometry, declares lock and recovers pixel x/y.
// Define VIDEO_RX_RGB565_EN to emit pixel_data as zero-extended RGB565 instead of the raw 24-bit pixel.
module video_timing_rx #(
    parameter int H_TOTAL     = 2200,
    parameter int H_DISP      = 1920,
    parameter int V_TOTAL     = 1125,
    parameter int V_DISP      = 1080,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic        video_hs,
    input  logic        video_vs,
    input  logic        video_de,
    input  logic [23:0] video_rgb,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [11:0] pixel_xpos,
    output logic [11:0] pixel_ypos,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_disp,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_v_disp
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_next;

    logic        s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de;
    logic [23:0] s1_rgb, s2_rgb, rgb_fmt;
    logic        hs_fall, vs_fall, de_q;
    logic [11:0] h_cnt, de_cnt, v_cnt, act_cnt, x_cnt, y_cnt, last_len, last_de;
    logic        geom_ok;
    logic [3:0]  match_cnt, match_next;
    logic        line_active, line_bad, frame_ok, timeout;
    logic        err_next, lock_set, lock_clr;

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            {s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de} <= '0;
            s1_rgb  <= '0;
            s2_rgb  <= '0;
            hs_fall <= 1'b0;
            vs_fall <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            s1_hs  <= video_hs;
            s1_vs  <= video_vs;
            s1_de  <= video_de;
            s1_rgb <= video_rgb;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_de  <= s1_de;
            s2_rgb <= s1_rgb;
            // Edge flags are registered so each one lines up with the s2 sample it belongs to.
            hs_fall <= s2_hs & ~s1_hs;
            vs_fall <= s2_vs & ~s1_vs;
            de_q    <= s2_de;
        end
    end

    always_comb begin
        line_active = hs_fall && (de_cnt != '0);
        line_bad    = hs_fall && ((h_cnt != 12'(H_TOTAL)) ||
                                  (line_active && (de_cnt != 12'(H_DISP))));
        frame_ok    = geom_ok && !line_bad &&
                      ((v_cnt + {11'd0, hs_fall}) == 12'(V_TOTAL)) &&
                      ((act_cnt + {11'd0, line_active}) == 12'(V_DISP));
        match_next  = frame_ok ? match_cnt + 4'd1 : '0;
        timeout     = !hs_fall && (h_cnt == 12'hFFE);
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) state <= SEARCH;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        lock_set   = 1'b0;
        lock_clr   = 1'b0;
        if (timeout) begin
            state_next = SEARCH;
            err_next   = 1'b1;
            lock_clr   = 1'b1;
        end else begin
            case (state)
                SEARCH:  if (vs_fall) state_next = MEASURE;
                MEASURE: if (vs_fall && (match_next == 4'(LOCK_FRAMES))) begin
                    state_next = LOCKED;
                    lock_set   = 1'b1;
                end
                LOCKED:  if ((hs_fall && (h_cnt != 12'(H_TOTAL))) || (vs_fall && !frame_ok)) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                    lock_clr   = 1'b1;
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            {h_cnt, de_cnt, v_cnt, act_cnt, last_len, last_de} <= '0;
            geom_ok   <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (hs_fall)            h_cnt <= 12'd1;
            else if (h_cnt != '1)   h_cnt <= h_cnt + 12'd1;

            if (hs_fall) begin
                de_cnt   <= {11'd0, s2_de};
                last_len <= h_cnt;
                if (line_active) last_de <= de_cnt;
            end else if (s2_de && (de_cnt != '1)) begin
                de_cnt <= de_cnt + 12'd1;
            end

            if (vs_fall) begin
                v_cnt   <= '0;
                act_cnt <= '0;
                geom_ok <= 1'b1;
            end else begin
                if (hs_fall && (v_cnt != '1)) v_cnt   <= v_cnt + 12'd1;
                if (line_active)              act_cnt <= act_cnt + 12'd1;
                if (line_bad)                 geom_ok <= 1'b0;
            end

            if (state != MEASURE) match_cnt <= '0;
            else if (vs_fall)     match_cnt <= match_next;
        end
    end

`ifdef VIDEO_RX_RGB565_EN
    assign rgb_fmt = {8'd0, s2_rgb[23:19], s2_rgb[15:10], s2_rgb[7:3]};
`else
    assign rgb_fmt = s2_rgb;
`endif

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            {pixel_valid, line_start, frame_start, locked, timing_err} <= '0;
            pixel_data   <= '0;
            pixel_xpos   <= '0;
            pixel_ypos   <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            meas_h_total <= '0;
            meas_h_disp  <= '0;
            meas_v_total <= '0;
            meas_v_disp  <= '0;
        end else begin
            line_start  <= hs_fall;
            frame_start <= vs_fall;
            timing_err  <= err_next;
            if (lock_clr)      locked <= 1'b0;
            else if (lock_set) locked <= 1'b1;
            pixel_valid <= s2_de & locked;
            pixel_data  <= rgb_fmt;

            if (hs_fall) begin
                pixel_xpos <= '0;
                x_cnt      <= {11'd0, s2_de};
            end else begin
                pixel_xpos <= x_cnt;
                if (s2_de && (x_cnt != '1)) x_cnt <= x_cnt + 12'd1;
            end

            if (vs_fall) begin
                pixel_ypos <= '0;
                y_cnt      <= '0;
            end else begin
                pixel_ypos <= y_cnt;
                if (!s2_de && de_q && (y_cnt != '1)) y_cnt <= y_cnt + 12'd1;
            end

            // Measurements include the line closed by an hs fall coincident with the vs fall.
            if (vs_fall && (state != SEARCH)) begin
                meas_v_total <= v_cnt + {11'd0, hs_fall};
                meas_v_disp  <= act_cnt + {11'd0, line_active};
                meas_h_total <= hs_fall ? h_cnt : last_len;
                meas_h_disp  <= line_active ? de_cnt : last_de;
            end
        end
    end

endmodule

// File: doc/video_timing_rx.md
# video_timing_rx

Receive-side counterpart of the HDMI video timing generator. It samples an incoming hs/vs/de/RGB stream and measures line and frame geometry against configured parameters. It declares lock and recovers per-pixel x/y coordinates for downstream capture logic, such as the frame writer feeding SDRAM. Sync pulses are active-low, matching the generator's output convention.

## Interface
- H_TOTAL, 2200, expected clocks per line
- H_DISP, 1920, expected active pixels per line
- V_TOTAL, 1125, expected lines per frame
- V_DISP, 1080, expected active lines per frame
- LOCK_FRAMES, 2, consecutive matching frames required for lock (1..15)

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- sys_rst  in  1  synchronous, active-high reset
- video_hs  in  1  horizontal sync, low during pulse
- video_vs  in  1  vertical sync, low during pulse
- video_de  in  1  data enable
- video_rgb  in  24  pixel {R,G,B}
- pixel_valid  out  1  active pixel; only asserted while locked
- pixel_data  out  24  pixel data; see Configuration
- pixel_xpos  out  12  0-based column of pixel_data
- pixel_ypos  out  12  0-based active row of pixel_data
- line_start  out  1  1-cycle pulse on each hs falling edge
- frame_start  out  1  1-cycle pulse on each vs falling edge
- locked  out  1  geometry matches the parameters
- timing_err  out  1  1-cycle pulse: lock lost or line timeout
- meas_h_total, meas_h_disp, meas_v_total, meas_v_disp  out  12 each  last measured geometry

## Operation
- **Input stage:** all inputs are registered once (stage s1), then again (s2).
- **Edge detection:** a falling edge is s2 = 1 and s1 = 0.
- **h_cnt:** increments every clock and is cleared to 1 on an hs fall. At the fall, h_cnt is latched as the line length.
- **de_cnt:** counts de-high clocks in the current line. It is latched and cleared on an hs fall.
- **v_cnt:** counts hs falls since the last vs fall. An hs fall coincident with a vs fall counts toward the closing frame. The new frame then starts at 0.
- **act_cnt:** counts lines with de_cnt ≠ 0.
- **Frame close (vs fall):**
  - Update meas_v_total = v_cnt and meas_v_disp = act_cnt.
  - meas_h_total is the last latched line length; meas_h_disp is the de_cnt of the last active line.
  - The frame matches if every line length == H_TOTAL, every nonzero de_cnt == H_DISP, v_cnt == V_TOTAL and act_cnt == V_DISP.
- **Coordinates:**
  - xpos increments on each de clock, saturates at 4095, and clears on an hs fall.
  - ypos increments on the first de-low clock after a de run, saturates at 4095, and clears on a vs fall.
- **State machine** (match_cnt is a 4-bit counter):
  - SEARCH: wait for a vs fall, clear all counters and match_cnt, then go to MEASURE. The frame partially seen before that fall is never judged.
  - MEASURE: at each vs fall, a match increments match_cnt and a mismatch clears it. When match_cnt == LOCK_FRAMES, set locked and go to LOCKED.
  - LOCKED: a line length ≠ H_TOTAL at any hs fall, or a frame mismatch, pulses timing_err, clears locked and returns to SEARCH.
- **Timeout:** h_cnt reaching 4095 in any state pulses timing_err, clears locked and goes to SEARCH. h_cnt holds at 4095.
- **Reset:** every output goes to 0, state goes to SEARCH, and all counters clear. Reset mid-frame discards that frame.

## Timing
- Input to pixel_valid/pixel_data/pixel_xpos/pixel_ypos latency is 3 clocks (s1, s2, output register).
- line_start and frame_start are asserted 3 clocks after the corresponding input edge.
- meas_* registers and locked update in the same cycle as frame_start.
- timing_err is asserted 3 clocks after the offending hs or vs edge.
- pixel_valid = s2 de AND locked, registered. Pixels are valid starting with the first frame after locked rises.

## Configuration
- Macro: VIDEO_RX_RGB565_EN.
- Defined: pixel_data = {8'd0, R[7:3], G[7:2], B[7:3]}.
- Undefined: pixel_data = video_rgb passthrough.
- Timing and latency are identical in both builds.

## Test plan
- Parameters for all tests: H_TOTAL=20, H_DISP=12, V_TOTAL=10, V_DISP=6, LOCK_FRAMES=2, using a compliant source.
- **Lock acquisition:** drive compliant frames → locked rises at the 3rd vs fall. meas_* read 20/12/10/6, and pixel_valid asserts 72 times in the next frame.
- **Coordinates:** drive RGB = {ypos, xpos} pattern → each valid pixel_xpos/ypos matches the embedded value; the first pixel is (0,0) and the last is (11,5).
- **Lost line:** while locked, shorten one line to 19 clocks → timing_err pulses once 3 clocks after that hs fall, locked drops, and relock takes 2 good frames.
- **Timeout and reset:** hold hs high 5000 clocks → timing_err pulses once, then no further pulses. A mid-frame sys_rst clears all outputs to 0.
- **RGB565:** build with VIDEO_RX_RGB565_EN, input 24'hFF8040 → pixel_data = 24'h00FC08.
